// File: rtl/gpio_keypad_pkg.sv
// Shared constants and types for the GPIO keypad scanner slice.
package gpio_keypad_pkg;

  localparam int unsigned ROWS_DEFAULT = 4;
  localparam int unsigned COLS_DEFAULT = 4;
  localparam int unsigned KEY_W        = 4;
  localparam int unsigned FIFO_DEPTH   = 4;

  typedef logic [KEY_W-1:0] key_code_t;

endpackage

// File: rtl/gpio_keypad_scanner_key_fifo.sv
// Small synchronous key-code FIFO; a push into a full queue is accepted
// only when a pop frees a slot on the same edge.
import gpio_keypad_pkg::*;

module key_fifo (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  key_code_t din,
  output logic      full,
  output logic      empty,
  output key_code_t head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  key_code_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_q;
  logic [PTR_W-1:0]   wr_q;
  logic [PTR_W:0]     cnt_q;
  logic               do_pop;
  logic               do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/gpio_keypad_scanner.sv
// 4x4 key matrix scanner: row scan, frame debounce, press-event queue.
import gpio_keypad_pkg::*;

module gpio_keypad_scanner #(
  parameter int unsigned ROWS     = ROWS_DEFAULT,
  parameter int unsigned COLS     = COLS_DEFAULT,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic [ROWS-1:0]  row_drive,
  input  logic [COLS-1:0]  col_sense,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun
);

  localparam int unsigned NKEYS   = ROWS * COLS;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE + 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic [NKEYS-1:0]   snap_q,  snap_d;
  logic [NKEYS-1:0]   prev_q,  prev_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [NKEYS-1:0]   deb_q,   deb_d;
  logic [NKEYS-1:0]   press_q, press_d;
  logic               load_q,  load_d;
  logic [NKEYS-1:0]   pend_q,  pend_d;
  logic               ovr_q,   ovr_d;

  logic [NKEYS-1:0]   raw;
  logic               last_dwell;
  logic               frame_done;
  logic               push_valid;
  key_code_t          push_code;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign row_drive = ~(ROWS'(1) << row_q);
  assign key_valid = !fifo_empty;
  assign key_held  = |deb_q;
  assign overrun   = ovr_q;
  assign pop       = key_ack && key_valid;

  // Scan counters, frame assembly and debounce; raw merges the row being
  // sampled this cycle so the frame is complete on the same edge.
  always_comb begin
    dwell_d    = dwell_q;
    row_d      = row_q;
    snap_d     = snap_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    press_d    = press_q;
    load_d     = 1'b0;
    last_dwell = (dwell_q == DWELL_W'(SCAN_DIV - 1));
    frame_done = last_dwell && (row_q == ROW_W'(ROWS - 1));
    raw        = snap_q;
    raw[int'(row_q) * COLS +: COLS] = ~col_sense;

    if (last_dwell) begin
      dwell_d = '0;
      snap_d  = raw;
      row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    if (frame_done) begin
      prev_d = raw;
      if (raw == prev_q) begin
        cnt_d = (cnt_q == CNT_W'(DEBOUNCE)) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = CNT_W'(1);
      end
      if (cnt_d == CNT_W'(DEBOUNCE)) begin
        deb_d   = raw;
        press_d = raw & ~deb_q;
        load_d  = 1'b1;
      end
    end
  end

  // Pending-press mask: lowest set bit goes to the queue each cycle.
  always_comb begin
    push_valid = 1'b0;
    push_code  = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (pend_q[i] && !push_valid) begin
        push_valid = 1'b1;
        push_code  = KEY_W'(i);
      end
    end
    pend_d = pend_q;
    if (push_valid) begin
      pend_d = pend_d & ~(NKEYS'(1) << push_code);
    end
    if (load_q) begin
      pend_d = pend_d | press_q;
    end
    ovr_d = ovr_q | (push_valid && fifo_full && !pop);
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_q <= '0;
      row_q   <= '0;
      snap_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      press_q <= '0;
      load_q  <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      load_q  <= load_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  key_fifo u_key_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_valid),
    .pop   (pop),
    .din   (push_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (key_code)
  );

endmodule

// File: tb/tb_gpio_keypad_scanner.sv
// Bench for gpio_keypad_scanner: frame-level behavioural model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_gpio_keypad_scanner;

  localparam int SD    = 16;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        key_ack = 1'b0;
  logic [15:0] keys    = '0;
  logic [3:0]  row_drive;
  logic [3:0]  col_sense;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clock = ~clock;

  gpio_keypad_scanner #(
    .ROWS     (4),
    .COLS     (4),
    .SCAN_DIV (SD),
    .DEBOUNCE (DB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row_drive (row_drive),
    .col_sense (col_sense),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_drive[r] && keys[r*4+c]) col_sense[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cyc;
  logic [15:0] m_snap, m_prev, m_deb, m_press, m_pend;
  int          m_cnt;
  bit          m_load, m_ovr;
  logic [3:0]  m_q[$];

  always @(posedge clock) begin
    if (reset) begin
      m_cyc = 0; m_snap = '0; m_prev = '0; m_deb = '0; m_press = '0;
      m_pend = '0; m_cnt = 0; m_load = 0; m_ovr = 0;
      m_q.delete();
    end else begin
      int row;
      int lo;
      if (key_ack && m_q.size() > 0) void'(m_q.pop_front());
      lo = -1;
      for (int i = 0; i < 16; i++) if (m_pend[i]) begin lo = i; break; end
      if (lo >= 0) begin
        m_pend[lo] = 1'b0;
        if (m_q.size() < 4) m_q.push_back(4'(lo));
        else m_ovr = 1'b1;
      end
      if (m_load) m_pend = m_pend | m_press;
      m_load = 0;
      if (m_cyc % SD == SD - 1) begin
        row = (m_cyc / SD) % 4;
        m_snap[row*4 +: 4] = keys[row*4 +: 4];
        if (row == 3) begin
          if (m_snap == m_prev) m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
          else m_cnt = 1;
          m_prev = m_snap;
          if (m_cnt == DB) begin
            m_press = m_snap & ~m_deb;
            m_deb   = m_snap;
            m_load  = 1;
          end
        end
      end
      m_cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clock) begin
    #1;
    if (started) begin
      logic [3:0] exp_rd;
      exp_rd = ~(4'b0001 << ((m_cyc / SD) % 4));
      check("row_drive", row_drive, exp_rd);
      check("key_valid", key_valid, m_q.size() > 0);
      if (m_q.size() > 0) check("key_code", key_code, m_q[0]);
      check("key_held", key_held, m_deb != 0);
      check("overrun", overrun, m_ovr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clock) key_ack = 1'b1;
    @(negedge clock) key_ack = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget, output int n);
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!key_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_key_valid required=key_valid_within_%0d", name, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit any;

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    started = 1'b1;
    check("rst_row_drive", row_drive, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    check("rst_overrun", overrun, 0);

    // Ack while empty
    ack_pulse();
    tick(2);
    check("empty_ack_code", key_code, 0);
    check("empty_ack_valid", key_valid, 0);
    check("empty_ack_overrun", overrun, 0);

    // Single press, code 9
    keys = 16'h0200;
    wait_valid("single", 3*FRAME + 10, n);
    check("single_latency_ok", n <= 3*FRAME + 2, 1);
    check("single_code", key_code, 9);
    check("single_held", key_held, 1);
    ack_pulse();
    keys = '0;
    tick(4*FRAME);
    check("single_no_second", key_valid, 0);
    check("single_released", key_held, 0);

    // Bounce: toggle every frame for 6 frames, then release
    do_reset();
    any = 0;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      repeat (FRAME) begin @(negedge clock); if (key_valid) any = 1; end
    end
    keys = '0;
    repeat (4*FRAME) begin @(negedge clock); if (key_valid) any = 1; end
    check("bounce_no_event", any, 0);
    check("bounce_not_held", key_held, 0);

    // Simultaneous codes 12 and 3
    do_reset();
    keys = 16'h1008;
    wait_valid("simul", 3*FRAME + 10, n);
    check("simul_first", key_code, 3);
    ack_pulse();
    check("simul_second_valid", key_valid, 1);
    check("simul_second", key_code, 12);
    ack_pulse();
    check("simul_drained", key_valid, 0);
    keys = '0;
    tick(4*FRAME);

    // Overrun: five sequential presses, no ack
    do_reset();
    for (int k = 0; k < 5; k++) begin
      keys = 16'(1) << k;
      tick(4*FRAME);
    end
    check("ovr_set", overrun, 1);
    for (int k = 0; k < 4; k++) begin
      check("ovr_valid", key_valid, 1);
      check("ovr_code", key_code, k);
      ack_pulse();
    end
    check("ovr_drained", key_valid, 0);
    keys = '0;
    tick(4*FRAME);
    check("ovr_sticky", overrun, 1);

    // Fifth push lands on the same edge as an ack of a full queue
    do_reset();
    keys = 16'h001F;
    wait_valid("coinc", 3*FRAME + 10, n);
    tick(2);
    ack_pulse();
    check("coinc_no_overrun", overrun, 0);
    for (int k = 1; k < 5; k++) begin
      check("coinc_code", key_code, k);
      ack_pulse();
    end
    check("coinc_drained", key_valid, 0);
    keys = '0;
    tick(4*FRAME);

    // Reset during row 2 with two codes queued, keys still held
    do_reset();
    keys = 16'h0060;
    wait_valid("mid", 3*FRAME + 10, n);
    tick(2);
    n = 0;
    while (row_drive != 4'b1011 && n < 2*FRAME) begin @(negedge clock); n++; end
    check("mid_row2_reached", row_drive, 4'b1011);
    tick(3);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_row_drive", row_drive, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_held", key_held, 0);
    reset = 1'b0;
    wait_valid("mid_redetect", 3*FRAME + 10, n);
    check("mid_redetect_code", key_code, 5);
    keys = '0;
    tick(4*FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_keypad_scanner.md
# gpio_keypad_scanner

Input-side counterpart to the GPIO expansion board display path: scans a 4x4 key matrix wired to the bidirectional GPIO header, debounces it, and queues key-press codes for the core. The core reads them through a valid/ack handshake. Sits at top level between the GPIO header pins and the core's memory-mapped input logic, clocked by the core clock.

## Interface
Parameters:
- ROWS, 4, matrix rows (driven)
- COLS, 4, matrix columns (sensed)
- SCAN_DIV, 50000, clock cycles each row is driven (dwell); minimum 16
- DEBOUNCE, 4, consecutive identical frames required to accept a state change; minimum 1

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- row_drive  out  ROWS  active-low one-hot row select
- col_sense  in  COLS  active-low column inputs, pulled up externally
- key_code  out  4  head-of-queue key code, row*COLS+col
- key_valid  out  1  queue non-empty
- key_ack  in  1  pop head; single-cycle pulse from core
- key_held  out  1  any key in debounced-pressed state
- overrun  out  1  sticky: a press event was dropped

## Operation
- Scan: row index r counts 0..ROWS-1 and wraps. Dwell counter counts 0..SCAN_DIV-1. row_drive = ~(1<<r).
- Sampling: on the last dwell cycle, ~col_sense is captured into snapshot bits [r*COLS +: COLS]. Sampling at dwell end gives the lines time to settle. The row then advances.
- Frame: a frame completes when row ROWS-1 is sampled. This produces a 16-bit raw frame.
- Debounce:
  - raw frame == previous raw frame: stable_cnt increments, saturating at DEBOUNCE.
  - otherwise: stable_cnt = 1.
  - When stable_cnt reaches DEBOUNCE, the debounced state is loaded from the raw frame.
- Events:
  - new_press = raw & ~debounced_old, evaluated on each debounced load and OR-ed into a 16-bit pending mask.
  - Each cycle, the lowest set pending bit is pushed into the queue and cleared.
  - Releases generate no event.
- key_held = |debounced.
- Queue: key_fifo, 4 entries of 4 bits.
  - Push while full, with no pop that cycle: the event is discarded and overrun is set.
  - Push and pop in the same cycle while full: both happen, no overrun.
- key_ack while key_valid: head is popped. key_ack while empty: ignored.
- overrun clears only on reset.

## Timing
- Reset values:
  - row_drive = 4'b1110
  - key_code = 0, key_valid = 0, key_held = 0, overrun = 0
  - dwell counter, r, snapshot, debounced state, pending mask, stable_cnt and queue all cleared
- Frame period is ROWS*SCAN_DIV cycles.
- Latency, stable press to key_valid: at most (DEBOUNCE+1) frames + 2 cycles.
  - +1 cycle for the debounced load to reach the pending mask.
  - +1 cycle for the pending bit to reach the queue.
- key_code and key_valid are registered:
  - they update the cycle after a push into an empty queue;
  - they update the cycle after an ack.
- A pending mask with k bits drains in k cycles. This is always complete before the next frame because SCAN_DIV ≥ 16.
- Reset asserted mid-frame or mid-drain: all state returns to reset values on the next edge, and any pending or queued codes are lost.

## Structure
- Shared package gpio_keypad_pkg:
  - ROWS_DEFAULT, COLS_DEFAULT, KEY_W = 4
  - FIFO_DEPTH = 4
  - typedef key_code_t
- Sub-module key_fifo: synchronous 4x4 FIFO with push, pop, full, empty, head, and simultaneous push/pop support.
- Priority encoder for the pending mask stays inline.

## Test plan
All scenarios use SCAN_DIV=16, DEBOUNCE=2, so one frame = 64 cycles.

- **Single press:** hold col_sense[1]=0 only while row_drive=1011 (code 9). Required: key_valid rises within 3 frames + 2 cycles, key_code=9, key_held=1. Ack, then release. Required: no second event; key_held=0 after 2 stable frames.
- **Bounce:** toggle the code-9 press every frame for 6 frames, then release. Required: key_valid stays 0 throughout.
- **Simultaneous keys:** press codes 12 and 3 in the same frame. Required: queue yields 3 then 12, on consecutive acks.
- **Overrun:** with no ack, produce 5 sequential distinct presses (0,1,2,3,4). Required: queue holds 0,1,2,3 and overrun=1. Acks return 0,1,2,3, then key_valid=0. A push that coincides with a full-queue ack must not set overrun (check on a fresh reset).
- **Ack while empty:** pulse key_ack with key_valid=0. Required: no state change, key_code stays 0.
- **Reset mid-operation:** assert reset during row 2 dwell with 2 codes queued. Required: next cycle row_drive=1110, key_valid=0, overrun=0. Held keys are re-detected as new presses after reset.
